// File: rtl/fifo_rd_stream.sv
// Drain stage for the single-clock DPRAM FIFO: converts the FIFO read side into a
// ready/valid stream through a credit-limited skid queue, with optional packet framing.
module fifo_rd_stream #(
  parameter int WIDTH      = 8,
  parameter int SKID_DEPTH = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Enable,
  input  logic [15:0]      i_Pkt_Len,
  output logic             o_Fifo_Rd_En,
  input  logic             i_Fifo_Rd_DV,
  input  logic [WIDTH-1:0] i_Fifo_Rd_Data,
  input  logic             i_Fifo_Empty,
  output logic             o_Tx_DV,
  output logic [WIDTH-1:0] o_Tx_Data,
  output logic             o_Tx_Last,
  input  logic             i_Tx_Ready,
  output logic             o_Overflow
);

  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(SKID_DEPTH);
  localparam logic [CW:0]   CREDIT_C = (CW+1)'(SKID_DEPTH);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    occ;
  logic [CW-1:0]    infl;
  logic [15:0]      count;
  logic [CW:0]      credit_used;
  logic             full;
  logic             push;
  logic             pop;

  // Words already queued plus words requested but not yet returned must fit the queue.
  assign credit_used  = {1'b0, occ} + {1'b0, infl};
  assign o_Fifo_Rd_En = i_Enable && !i_Fifo_Empty && (credit_used < CREDIT_C);

  assign o_Tx_DV   = (occ != '0);
  assign o_Tx_Data = o_Tx_DV ? mem[rd_ptr] : '0;
  assign o_Tx_Last = o_Tx_DV && (i_Pkt_Len != 16'd0) && (count >= i_Pkt_Len - 16'd1);

  assign full = (occ == DEPTH_C);
  assign pop  = o_Tx_DV && i_Tx_Ready;
  assign push = i_Fifo_Rd_DV && (!full || pop);

  // Queue storage carries no reset; visibility is gated by occupancy.
  always_ff @(posedge i_Clk) begin
    if (push) mem[wr_ptr] <= i_Fifo_Rd_Data;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      infl       <= '0;
      count      <= '0;
      o_Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase

      case ({o_Fifo_Rd_En, i_Fifo_Rd_DV})
        2'b10:   infl <= infl + CW'(1);
        2'b01:   infl <= (infl != '0) ? infl - CW'(1) : infl;
        default: infl <= infl;
      endcase

      if (i_Fifo_Rd_DV && full && !pop) o_Overflow <= 1'b1;

      if (pop) count <= o_Tx_Last ? 16'd0 : count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a 2-cycle-latency FIFO model feeds the DUT, and a stream
// monitor checks order, framing, stall stability and the credit bound.
module tb_fifo_rd_stream;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [15:0]      pkt_len = 16'd0;
  logic             rd_en;
  logic             fifo_dv;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic             tx_dv;
  logic [WIDTH-1:0] tx_data;
  logic             tx_last;
  logic             tx_ready = 1'b0;
  logic             overflow;

  fifo_rd_stream #(.WIDTH(WIDTH), .SKID_DEPTH(DEPTH)) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .i_Enable       (enable),
    .i_Pkt_Len      (pkt_len),
    .o_Fifo_Rd_En   (rd_en),
    .i_Fifo_Rd_DV   (fifo_dv),
    .i_Fifo_Rd_Data (fifo_data),
    .i_Fifo_Empty   (fifo_empty),
    .o_Tx_DV        (tx_dv),
    .o_Tx_Data      (tx_data),
    .o_Tx_Last      (tx_last),
    .i_Tx_Ready     (tx_ready),
    .o_Overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Source words in load order; they are also the expected delivery order.
  logic [WIDTH-1:0] src_mem [0:1023];
  int               src_wr = 0;
  int               fifo_head = 0;
  logic             dv_s1;
  logic [WIDTH-1:0] d_s1;

  assign fifo_empty = (fifo_head == src_wr);

  // FIFO with 2-cycle read latency, flushed by the shared reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_head <= src_wr;
      dv_s1     <= 1'b0;
      d_s1      <= '0;
      fifo_dv   <= 1'b0;
      fifo_data <= '0;
    end else begin
      dv_s1     <= rd_en;
      d_s1      <= rd_en ? src_mem[fifo_head] : WIDTH'($urandom);
      if (rd_en) fifo_head <= fifo_head + 1;
      fifo_dv   <= dv_s1;
      fifo_data <= d_s1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor state
  int               issued, delivered, exp_rd, beat, lasts, gaps;
  logic             stall_prev, started;
  logic [WIDTH-1:0] stall_data;

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        issued = 0; delivered = 0; exp_rd = src_wr; beat = 0; lasts = 0;
        gaps = 0; stall_prev = 1'b0; started = 1'b0; stall_data = '0;
      end else begin
        if (rd_en) issued++;
        chk("credit_bound", 32'((issued - delivered) <= DEPTH), 32'd1);
        if (stall_prev) begin
          chk("hold_dv", 32'(tx_dv), 32'd1);
          chk("hold_data", 32'(tx_data), 32'(stall_data));
        end
        if (tx_dv && tx_ready) begin
          if (exp_rd >= src_wr) chk("extra_word", 32'd1, 32'd0);
          else chk("data", 32'(tx_data), 32'(src_mem[exp_rd]));
          exp_rd++;
          chk("last", 32'(tx_last),
              (pkt_len != 16'd0) ? 32'(((beat + 1) % int'(pkt_len)) == 0) : 32'd0);
          if (tx_last) lasts++;
          beat++;
          delivered++;
          started = 1'b1;
        end else if (started && tx_ready && !tx_dv && exp_rd < src_wr) begin
          gaps++;
        end
        stall_prev = tx_dv && !tx_ready;
        stall_data = tx_data;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input int n, input bit seq);
    for (int i = 0; i < n; i++) begin
      src_mem[src_wr] = seq ? WIDTH'(i + 1) : WIDTH'($urandom);
      src_wr++;
    end
  endtask

  task automatic run_until(input int n, input int pct, input int budget);
    int c;
    c = 0;
    while (delivered < n && c < budget) begin
      @(negedge clk);
      tx_ready = ($urandom_range(99) < pct);
      c++;
    end
    chk("run_timeout", 32'(delivered >= n), 32'd1);
  endtask

  typedef struct {
    logic [15:0] len;
    int          words;
    int          pct;
    int          exp_lasts;
    bit          b2b;
    bit          seq;
  } vec_t;

  vec_t vecs [5];
  int   first_idx;
  int   iss;

  initial begin
    vecs[0] = '{16'd0, 8,  100, 0, 1'b1, 1'b1};
    vecs[1] = '{16'd0, 20, 50,  0, 1'b0, 1'b0};
    vecs[2] = '{16'd3, 9,  100, 3, 1'b0, 1'b0};
    vecs[3] = '{16'd1, 5,  70,  5, 1'b0, 1'b0};
    vecs[4] = '{16'd4, 10, 60,  2, 1'b0, 1'b0};

    fork
      monitor_loop();
    join_none

    // Reset state
    #12;
    chk("rst_tx_dv", 32'(tx_dv), 32'd0);
    chk("rst_tx_last", 32'(tx_last), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    for (int k = 0; k < 5; k++) begin
      pkt_len  = vecs[k].len;
      tx_ready = 1'b0;
      enable   = 1'b1;
      do_reset();
      load(vecs[k].words, vecs[k].seq);
      run_until(vecs[k].words, vecs[k].pct, 600);
      chk("vec_delivered", 32'(delivered), 32'(vecs[k].words));
      chk("vec_lasts", 32'(lasts), 32'(vecs[k].exp_lasts));
      chk("vec_overflow", 32'(overflow), 32'd0);
      if (vecs[k].b2b) chk("b2b_gaps", 32'(gaps), 32'd0);
      @(negedge clk);
      chk("vec_drained", 32'(tx_dv), 32'd0);
    end

    // Backpressure: credit stops reads at the queue depth, head word held
    pkt_len  = 16'd0;
    tx_ready = 1'b0;
    enable   = 1'b1;
    do_reset();
    first_idx = src_wr;
    load(8, 1'b0);
    repeat (10) @(negedge clk);
    chk("stall_reads", 32'(issued), 32'(DEPTH));
    chk("stall_rd_en", 32'(rd_en), 32'd0);
    chk("stall_tx_dv", 32'(tx_dv), 32'd1);
    chk("stall_head", 32'(tx_data), 32'(src_mem[first_idx]));
    run_until(8, 100, 200);
    chk("stall_delivered", 32'(delivered), 32'd8);
    chk("stall_overflow", 32'(overflow), 32'd0);

    // Enable dropped mid-stream: in-flight words still arrive
    tx_ready = 1'b1;
    do_reset();
    load(12, 1'b0);
    repeat (4) @(negedge clk);
    enable = 1'b0;
    iss = issued;
    chk("en_outstanding", 32'((issued - delivered) >= 2), 32'd1);
    repeat (8) @(negedge clk);
    chk("en_no_reads", 32'(issued), 32'(iss));
    chk("en_inflight_delivered", 32'(delivered), 32'(iss));
    enable = 1'b1;
    run_until(12, 100, 200);
    chk("en_resume_delivered", 32'(delivered), 32'd12);
    chk("en_resume_issued", 32'(issued), 32'd12);

    // Asynchronous reset while the stream is valid
    pkt_len  = 16'd2;
    tx_ready = 1'b0;
    enable   = 1'b1;
    do_reset();
    load(6, 1'b0);
    repeat (5) @(negedge clk);
    chk("pre_rst_tx_dv", 32'(tx_dv), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_tx_dv", 32'(tx_dv), 32'd0);
    chk("async_tx_last", 32'(tx_last), 32'd0);
    chk("async_rd_en", 32'(rd_en), 32'd0);
    chk("async_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_tx_dv", 32'(tx_dv), 32'd0);
    load(4, 1'b0);
    run_until(4, 100, 200);
    chk("post_rst_delivered", 32'(delivered), 32'd4);
    chk("post_rst_lasts", 32'(lasts), 32'd2);
    chk("post_rst_overflow", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Downstream drain stage for the single-clock DPRAM FIFO. It turns the FIFO read side (read-enable strobe, delayed data-valid, empty flag) into a ready/valid stream. A small credit-managed skid queue sustains 1 word/cycle under backpressure. An optional word counter frames the stream into fixed-length packets with a last-word marker.

Parameters:
WIDTH, 8, data width; matches the FIFO WIDTH.
SKID_DEPTH, 4, skid queue entries; power of 2, minimum 2, at least FIFO read latency + 2.

Ports:
i_Clk  input  1  system clock
i_Rst_L  input  1  reset, asynchronous, active-low
i_Enable  input  1  permits new FIFO reads; level-sensitive
i_Pkt_Len  input  16  words per packet; 0 disables framing
o_Fifo_Rd_En  output  1  read strobe to FIFO
i_Fifo_Rd_DV  input  1  FIFO read data valid
i_Fifo_Rd_Data  input  WIDTH  FIFO read data
i_Fifo_Empty  input  1  FIFO empty flag
o_Tx_DV  output  1  stream valid
o_Tx_Data  output  WIDTH  stream data
o_Tx_Last  output  1  final word of packet; qualified by o_Tx_DV
i_Tx_Ready  input  1  consumer ready
o_Overflow  output  1  sticky error: data arrived with queue full

Behaviour:
- Clock and reset: single clock i_Clk; reset i_Rst_L is asynchronous, active-low. All state clears on reset: occupancy 0, in-flight 0, word count 0, o_Overflow 0. Consequently o_Tx_DV=0, o_Tx_Last=0, o_Fifo_Rd_En=0, o_Tx_Data=0.
- Queue: circular buffer of SKID_DEPTH x WIDTH with write pointer, read pointer and occupancy count (clog2(SKID_DEPTH)+1 bits).
- In-flight counter, same width as occupancy:
  - +1 on o_Fifo_Rd_En.
  - -1 on i_Fifo_Rd_DV.
  - Both in the same cycle: unchanged.
- o_Fifo_Rd_En (combinational) = i_Enable && !i_Fifo_Empty && (occupancy + in-flight < SKID_DEPTH). Credit-limited, so it never requests more than the queue can hold.
- Capture: on each edge with i_Fifo_Rd_DV=1, i_Fifo_Rd_Data is written at the write pointer, and the pointer wraps at SKID_DEPTH-1.
- Output:
  - o_Tx_DV = (occupancy != 0). o_Tx_Data = queue[read pointer]. Both are driven only from registered state.
  - Transfer = o_Tx_DV && i_Tx_Ready; it advances the read pointer (with wrap).
  - Latency: a word captured at edge N is presented with o_Tx_DV=1 from cycle N+1.
- Occupancy update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged. This is legal even at occupancy SKID_DEPTH.
- Overflow: i_Fifo_Rd_DV=1 with occupancy==SKID_DEPTH and no pop sets o_Overflow. The word is dropped and the flag clears only on reset. A correct FIFO never triggers this.
- o_Tx_DV stays asserted, with o_Tx_Data held stable, until a transfer.
- Framing:
  - 16-bit word counter increments on each transfer.
  - o_Tx_Last = o_Tx_DV && (i_Pkt_Len != 0) && (count >= i_Pkt_Len - 1).
  - A transfer with o_Tx_Last=1 resets the count to 0.
  - With i_Pkt_Len=0, o_Tx_Last stays 0 and the counter wraps freely.
  - i_Pkt_Len is sampled live; shrinking it mid-packet ends the packet on the next transfer.
- i_Enable low: no new reads are issued. In-flight words are still captured and the queue drains normally.
- i_Tx_Ready held low: the queue fills to SKID_DEPTH, then o_Fifo_Rd_En stays 0. No word is lost or duplicated.
- Reset mid-operation: queued and in-flight words are discarded. The FIFO shares i_Rst_L and is flushed with this block.

Test Plan:
1. Reset, FIFO holding 0x01..0x08, i_Tx_Ready=1, i_Pkt_Len=0 -> o_Tx_Data sequence 0x01..0x08 in order, back-to-back at 1 word/cycle once primed; o_Tx_Last=0; o_Overflow=0.
2. FIFO holding 20 words, i_Tx_Ready toggling 1/0 randomly -> all 20 words delivered in order, none duplicated; occupancy + in-flight never exceeds 4; o_Overflow=0.
3. i_Tx_Ready=0 for 10 cycles with FIFO non-empty -> exactly 4 reads issued, then o_Fifo_Rd_En=0; o_Tx_Data held at first word; release -> remaining words flow in order.
4. i_Pkt_Len=3, 9 words, i_Tx_Ready=1 -> o_Tx_Last=1 on words 3, 6 and 9 only.
5. Drop i_Enable mid-stream with 2 reads in flight -> no further o_Fifo_Rd_En; both in-flight words are captured and delivered; raise i_Enable -> reads resume.
6. Assert i_Rst_L=0 asynchronously while o_Tx_DV=1 -> o_Tx_DV, o_Tx_Last and o_Fifo_Rd_En go 0 immediately; after release, occupancy and word count are 0.
